// File: rtl/adc_mon_pkg.sv
// adc_mon_pkg: shared types and constants for the ADC monitor scheduler.
//   adc_state_e  - scheduler state encoding
//   TEMP / VCC   - ADC controller channel addresses for the two debug reads
//   round_len()  - cycles from TEMP_RD entry to the end of DONE
package adc_mon_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      TEMP_RD   = 3'd1,
      TEMP_WAIT = 3'd2,
      VOLT_RD   = 3'd3,
      VOLT_WAIT = 3'd4,
      DONE      = 3'd5
   } adc_state_e;

   localparam logic [7:0] TEMP = 8'h40;
   localparam logic [7:0] VCC  = 8'h41;

   function automatic int round_len(input int rd_pulse_w, input int capture_dly);
      return 2 * (rd_pulse_w + capture_dly) + 1;
   endfunction

endpackage

// File: rtl/adc_ema_filter.sv
// adc_ema_filter: per-channel exponential moving average.
//   clk, rst_n  - clock, synchronous active-low reset (also clears primed)
//   upd_i       - one-cycle strobe: fold sample_i into the average
//   sample_i    - new sample
//   avg_o       - filtered value (registered)
// The first update after reset loads the sample directly so the filter does
// not have to crawl up from zero.
module adc_ema_filter #(
   parameter int DATA_W   = 16,
   parameter int AVG_LOG2 = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              upd_i,
   input  logic [DATA_W-1:0] sample_i,
   output logic [DATA_W-1:0] avg_o
);

   logic                primed_q, primed_d;
   logic [DATA_W-1:0]   avg_q, avg_d;
   logic signed [DATA_W:0] diff;
   logic signed [DATA_W:0] step;
   logic [DATA_W-1:0]   avg_upd;

   always_comb begin
      // One extra bit keeps the difference exact; the sum always lands
      // between avg and sample, so truncation back to DATA_W is lossless.
      diff    = $signed({1'b0, sample_i}) - $signed({1'b0, avg_q});
      step    = diff >>> AVG_LOG2;
      avg_upd = DATA_W'($unsigned({1'b0, avg_q}) + $unsigned(step));
      avg_d    = avg_q;
      primed_d = primed_q;
      if (upd_i) begin
         avg_d    = primed_q ? avg_upd : sample_i;
         primed_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         avg_q    <= '0;
         primed_q <= 1'b0;
      end else begin
         avg_q    <= avg_d;
         primed_q <= primed_d;
      end
   end

   assign avg_o = avg_q;

endmodule

// File: rtl/adc_mon_sched.sv
// adc_mon_sched: periodic temperature/voltage read scheduler for the ADC
// read controller, with per-channel EMA filtering and sticky alarms.
//   clk, rst_n            - clock, synchronous active-low reset
//   enable                - allow periodic rounds every PERIOD_CYC cycles
//   force_rd              - one-cycle request for an immediate round
//   alarm_clr             - clears both sticky alarms (a same-cycle set wins)
//   temp_hi_thr           - temperature high threshold
//   volt_lo_thr/_hi_thr   - voltage window
//   pdata                 - result returned by the ADC read controller
//   dbg_temp_rd/_volt_rd  - read request lines to the ADC controller
//   temp_raw/volt_raw     - last captured codes
//   temp_avg/volt_avg     - filtered codes
//   temp_alarm/volt_alarm - sticky threshold alarms
//   sample_valid          - one-cycle strobe in the DONE cycle
//   busy                  - high while a round is in progress
//
// state     | meaning
// ----------+-----------------------------------------------
// IDLE      | waiting for a periodic or forced trigger
// TEMP_RD   | temperature request held high RD_PULSE_W cycles
// TEMP_WAIT | CAPTURE_DLY cycles, pdata captured on the last
// VOLT_RD   | voltage request held high RD_PULSE_W cycles
// VOLT_WAIT | CAPTURE_DLY cycles, pdata captured on the last
// DONE      | strobe sample_valid, evaluate alarms
module adc_mon_sched
   import adc_mon_pkg::*;
#(
   parameter int PERIOD_CYC  = 1000000,
   parameter int RD_PULSE_W  = 4,
   parameter int CAPTURE_DLY = 16,
   parameter int AVG_LOG2    = 3,
   parameter int DATA_W      = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              force_rd,
   input  logic              alarm_clr,
   input  logic [DATA_W-1:0] temp_hi_thr,
   input  logic [DATA_W-1:0] volt_lo_thr,
   input  logic [DATA_W-1:0] volt_hi_thr,
   input  logic [DATA_W-1:0] pdata,
   output logic              dbg_temp_rd,
   output logic              dbg_volt_rd,
   output logic [DATA_W-1:0] temp_raw,
   output logic [DATA_W-1:0] volt_raw,
   output logic [DATA_W-1:0] temp_avg,
   output logic [DATA_W-1:0] volt_avg,
   output logic              temp_alarm,
   output logic              volt_alarm,
   output logic              sample_valid,
   output logic              busy
);

   localparam int TMR_MAX = (RD_PULSE_W > CAPTURE_DLY) ? RD_PULSE_W : CAPTURE_DLY;
   localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
   localparam int CNT_W   = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;

   localparam logic [TMR_W-1:0] RD_LOAD  = TMR_W'(RD_PULSE_W - 1);
   localparam logic [TMR_W-1:0] CAP_LOAD = TMR_W'(CAPTURE_DLY - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD_CYC - 1);

   adc_state_e        state_q, state_d;
   logic [TMR_W-1:0]  tmr_q, tmr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              pend_q, pend_d;
   logic              trig, start;
   logic              temp_cap, volt_cap;

   logic              dbg_temp_rd_q, dbg_temp_rd_d;
   logic              dbg_volt_rd_q, dbg_volt_rd_d;
   logic              busy_q, busy_d;
   logic              valid_q, valid_d;
   logic              temp_alarm_q, temp_alarm_d;
   logic              volt_alarm_q, volt_alarm_d;
   logic [DATA_W-1:0] temp_raw_q, temp_raw_d;
   logic [DATA_W-1:0] volt_raw_q, volt_raw_d;
   logic [DATA_W-1:0] temp_avg_w, volt_avg_w;

   // Period counter and one-deep pending trigger. A trigger seen while IDLE
   // starts the round directly, so the first periodic round enters TEMP_RD
   // PERIOD_CYC cycles after enable rises; triggers while busy coalesce.
   always_comb begin
      trig   = enable && (cnt_q == CNT_LAST);
      cnt_d  = '0;
      if (enable && !trig)
         cnt_d = cnt_q + 1'b1;
      start  = (state_q == IDLE) && (pend_q || trig || force_rd);
      pend_d = start ? 1'b0 : (pend_q || trig || force_rd);
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         tmr_q   <= '0;
         cnt_q   <= '0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
      end
   end

   // Next-state logic; the down-counter's terminal count ends each phase
   always_comb begin
      state_d  = state_q;
      tmr_d    = tmr_q;
      temp_cap = 1'b0;
      volt_cap = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = TEMP_RD;
               tmr_d   = RD_LOAD;
            end
         end
         TEMP_RD: begin
            if (tmr_q == '0) begin
               state_d = TEMP_WAIT;
               tmr_d   = CAP_LOAD;
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
         end
         TEMP_WAIT: begin
            if (tmr_q == '0) begin
               temp_cap = 1'b1;
               state_d  = VOLT_RD;
               tmr_d    = RD_LOAD;
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
         end
         VOLT_RD: begin
            if (tmr_q == '0) begin
               state_d = VOLT_WAIT;
               tmr_d   = CAP_LOAD;
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
         end
         VOLT_WAIT: begin
            if (tmr_q == '0) begin
               volt_cap = 1'b1;
               state_d  = DONE;
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output logic. Strobes are decoded from the next state so the registered
   // outputs line up with the state they describe.
   always_comb begin
      dbg_temp_rd_d = (state_d == TEMP_RD);
      dbg_volt_rd_d = (state_d == VOLT_RD);
      busy_d        = (state_d != IDLE);
      valid_d       = (state_d == DONE);
      temp_raw_d    = temp_cap ? pdata : temp_raw_q;
      volt_raw_d    = volt_cap ? pdata : volt_raw_q;

      temp_alarm_d = temp_alarm_q;
      if (alarm_clr)
         temp_alarm_d = 1'b0;
      if ((state_q == DONE) && (temp_avg_w > temp_hi_thr))
         temp_alarm_d = 1'b1;

      volt_alarm_d = volt_alarm_q;
      if (alarm_clr)
         volt_alarm_d = 1'b0;
      if ((state_q == DONE) &&
          ((volt_avg_w < volt_lo_thr) || (volt_avg_w > volt_hi_thr)))
         volt_alarm_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dbg_temp_rd_q <= 1'b0;
         dbg_volt_rd_q <= 1'b0;
         busy_q        <= 1'b0;
         valid_q       <= 1'b0;
         temp_alarm_q  <= 1'b0;
         volt_alarm_q  <= 1'b0;
         temp_raw_q    <= '0;
         volt_raw_q    <= '0;
      end else begin
         dbg_temp_rd_q <= dbg_temp_rd_d;
         dbg_volt_rd_q <= dbg_volt_rd_d;
         busy_q        <= busy_d;
         valid_q       <= valid_d;
         temp_alarm_q  <= temp_alarm_d;
         volt_alarm_q  <= volt_alarm_d;
         temp_raw_q    <= temp_raw_d;
         volt_raw_q    <= volt_raw_d;
      end
   end

   adc_ema_filter #(
      .DATA_W   (DATA_W),
      .AVG_LOG2 (AVG_LOG2)
   ) u_temp_ema (
      .clk      (clk),
      .rst_n    (rst_n),
      .upd_i    (temp_cap),
      .sample_i (pdata),
      .avg_o    (temp_avg_w)
   );

   adc_ema_filter #(
      .DATA_W   (DATA_W),
      .AVG_LOG2 (AVG_LOG2)
   ) u_volt_ema (
      .clk      (clk),
      .rst_n    (rst_n),
      .upd_i    (volt_cap),
      .sample_i (pdata),
      .avg_o    (volt_avg_w)
   );

   assign dbg_temp_rd  = dbg_temp_rd_q;
   assign dbg_volt_rd  = dbg_volt_rd_q;
   assign temp_raw     = temp_raw_q;
   assign volt_raw     = volt_raw_q;
   assign temp_avg     = temp_avg_w;
   assign volt_avg     = volt_avg_w;
   assign temp_alarm   = temp_alarm_q;
   assign volt_alarm   = volt_alarm_q;
   assign sample_valid = valid_q;
   assign busy         = busy_q;

endmodule

// File: doc/adc_mon_sched.md
Name: adc_mon_sched

Overview:
Periodic scheduler and post-processor for the on-chip ADC read controller. It sits directly upstream and downstream of that controller:
- it drives the controller's temperature and voltage debug-read request lines;
- it waits a fixed latency, then captures the controller's 16-bit pdata result;
- it keeps a filtered value per channel and raises sticky threshold alarms for the status/CSR logic.

Parameters:
PERIOD_CYC, 1000000, cycles between automatic sampling rounds (must exceed round length 2*(RD_PULSE_W+CAPTURE_DLY)+1).
RD_PULSE_W, 4, cycles each read-request line is held high (>=2).
CAPTURE_DLY, 16, cycles after request falls before pdata is sampled.
AVG_LOG2, 3, EMA shift; filter weight 1/2^AVG_LOG2.
DATA_W, 16, ADC result width.

Ports:
clk  in  1  system clock; one clock domain.
rst_n  in  1  reset, synchronous, active-low.
enable  in  1  allows periodic rounds.
force_rd  in  1  one-cycle request for an immediate round; honoured regardless of enable.
alarm_clr  in  1  clears both sticky alarms.
temp_hi_thr  in  DATA_W  temperature alarm threshold.
volt_lo_thr  in  DATA_W  voltage low threshold.
volt_hi_thr  in  DATA_W  voltage high threshold.
pdata  in  DATA_W  result returned by the ADC read controller.
dbg_temp_rd  out  1  temperature read request to the ADC controller.
dbg_volt_rd  out  1  voltage read request to the ADC controller.
temp_raw  out  DATA_W  last captured temperature code.
volt_raw  out  DATA_W  last captured voltage code.
temp_avg  out  DATA_W  filtered temperature.
volt_avg  out  DATA_W  filtered voltage.
temp_alarm  out  1  sticky: temp_avg > temp_hi_thr.
volt_alarm  out  1  sticky: volt_avg < volt_lo_thr or > volt_hi_thr.
sample_valid  out  1  one-cycle strobe when a round completes.
busy  out  1  high while state != IDLE.

Behaviour:
- Reset (rst_n low at a clk edge): all outputs 0, state IDLE, counters 0, pending 0, both EMA "primed" flags cleared. Reset mid-round aborts the round; request lines are low from the next cycle.
- Period counter:
  - counts 0..PERIOD_CYC-1 while enable=1; held at 0 while enable=0;
  - at count PERIOD_CYC-1 it sets pending, so the first round starts PERIOD_CYC cycles after enable rises.
- force_rd also sets pending. Pending is one-deep; triggers arriving while busy coalesce into it.
- State machine, all outputs registered:
  - IDLE -> TEMP_RD when pending; pending is cleared on this transition.
  - TEMP_RD: dbg_temp_rd=1 for exactly RD_PULSE_W cycles, then TEMP_WAIT.
  - TEMP_WAIT: CAPTURE_DLY cycles. On the last cycle temp_raw<=pdata and the temperature EMA updates; then VOLT_RD.
  - VOLT_RD / VOLT_WAIT: same sequence with dbg_volt_rd and volt_raw.
  - DONE: one cycle. sample_valid=1; alarms are evaluated on the updated averages. Then IDLE.
  - The two request lines are never high simultaneously.
- Latency: temp_raw updates RD_PULSE_W+CAPTURE_DLY cycles after the TEMP_RD entry edge. sample_valid rises 2*(RD_PULSE_W+CAPTURE_DLY) cycles after TEMP_RD entry.
- EMA per channel:
  - first capture after reset loads avg<=sample and sets primed;
  - thereafter avg <= avg + ((sample - avg) >>> AVG_LOG2);
  - the difference is formed signed in DATA_W+1 bits with an arithmetic shift and the result truncated to DATA_W; no overflow is possible.
- Alarms:
  - set in DONE when the condition holds; cleared by alarm_clr;
  - set and clear in the same cycle: set wins;
  - thresholds are unsigned compares sampled in DONE.
- enable falling mid-round: the current round completes; no new periodic trigger fires.

Decomposition:
- Package adc_mon_pkg holds:
  - the state enum (IDLE, TEMP_RD, TEMP_WAIT, VOLT_RD, VOLT_WAIT, DONE);
  - ADC channel address constants TEMP=8'h40, VCC=8'h41, used by documentation and bench;
  - the round-length function.
- One sub-module, adc_ema_filter (load/prime, update strobe, sample in, avg out), is instantiated twice.

Test Plan:
Bench parameters: PERIOD_CYC=100, RD_PULSE_W=4, CAPTURE_DLY=8, AVG_LOG2=2.
1. enable=1 from reset, pdata model returns 0x0100 on a temp request and 0x0C00 on a volt request -> dbg_temp_rd high 4 cycles at cycle 100; temp_raw=0x0100 at +12; sample_valid at +24; temp_avg=0x0100, volt_avg=0x0C00.
2. Second round with temp sample 0x0200 -> temp_avg=0x0140. Third round with sample 0x00C0 -> temp_avg=0x0120 (negative-difference path).
3. temp_hi_thr=0x0130 during round 2 -> temp_alarm=1 in DONE; it stays 1 after round 3. alarm_clr pulse coinciding with a set -> alarm stays 1. alarm_clr alone -> 0.
4. force_rd with enable=0 -> one round runs, busy high for 25 cycles. force_rd pulsed twice during busy -> exactly one extra round follows.
5. volt_lo_thr=0x0D00 with volt sample 0x0C00 -> volt_alarm=1. volt_hi_thr=0x0B00 with samples in range of lo -> alarm via hi compare only.
6. rst_n low during VOLT_WAIT -> next cycle all outputs 0 and busy=0. The next round's first capture primes the EMA, so avg equals the raw sample.
